key_sched_stream: RTL and testbench
===================================

Name: key_sched_stream

Overview:
- Iterative AES-128 key-schedule generator.
- Accepts one 128-bit cipher key and streams the 11 round keys (rounds 0..10), one per handshake.
- Sits upstream of the round-key-addition stage that feeds subBytes in the cipher datapath.
- Uses the existing sbox block for SubWord, so the round datapath and key path share the same S-box implementation.

Parameters:
- NR, 10, number of cipher rounds. Only 10 (AES-128) is supported; elaboration error otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- key  in  [7:0] x [0:3][0:3]  cipher key. key[w][b]: w = word 0..3, b = byte within word, b=0 is the first FIPS-197 byte.
- key_valid  in  1  key present.
- key_ready  out  1  block idle and able to accept a key.
- rk  out  [7:0] x [0:3][0:3]  current round key, same layout as key.
- rk_round  out  4  index 0..10 of rk.
- rk_last  out  1  high when rk_round == NR.
- rk_valid  out  1  rk is valid.
- rk_ready  in  1  consumer accepts rk.

Behaviour:
- Reset (asynchronous, rst=0) forces all of the following immediately:
  - state = IDLE, rk = all zeros, rk_round = 0;
  - rk_valid = 0, rk_last = 0, key_ready = 1.
- FSM states:
  - IDLE: key_ready = 1, rk_valid = 0.
  - EMIT: key_ready = 0, rk_valid = 1.
- IDLE -> EMIT on key_valid && key_ready: rk <= key, rk_round <= 0. Round key 0 is valid the cycle after acceptance (latency 1).
- EMIT with rk_valid && rk_ready:
  - if rk_round == NR: go to IDLE. rk_valid falls next cycle and key_ready rises the same cycle. rk holds its last value.
  - else: rk <= next(rk, RCON[rk_round]), rk_round += 1.
- EMIT with rk_ready = 0: rk, rk_round and rk_last hold stable (AXI-style; valid never drops without a handshake).
- next(rk, rc):
  - t = SubWord(RotWord(w3)) XOR {rc, 00, 00, 00}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - RotWord(b0,b1,b2,b3) = (b1,b2,b3,b0).
  - All arithmetic is bytewise XOR, 8-bit, with no carries.
- RCON[0..9] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- Throughput: with rk_ready held high, 11 consecutive cycles of valid, then 1 idle cycle before the next key can be accepted.
- key_valid during EMIT is ignored; the key is not sampled.
- rk_ready while in IDLE has no effect.
- Reset asserted mid-stream: the sequence is aborted with no partial output afterwards. After release the block is in IDLE awaiting a new key.
- All outputs are registered except key_ready and rk_valid, which decode directly from the state register.

Decomposition:
- Shared package (alongside the cipher defs):
  - Byte / Word / key-matrix typedefs (same matrix type as the cipher state);
  - RCON constant array;
  - NR constant;
  - FSM state enum.
- Sub-module key_sched_next: combinational next-round-key function. Instantiates 4x sbox and takes rk and rc as inputs.
- key_sched_stream holds the FSM, registers and handshake.

Test Plan:
- FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1:
  - round0 equals the key;
  - round1 = a0fafe17 88542cb1 23a33939 2a6c7605;
  - round10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_last=1;
  - key_ready returns to 1 exactly 12 cycles after acceptance.
- All-zero key:
  - round1 = 62636363 x4;
  - round10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- Backpressure, A.1 key:
  - hold rk_ready=0 for 3 cycles while rk_round=2;
  - rk stays f2c295f2 7a96b943 5935807a 7359f67f and rk_valid stays 1;
  - round3 follows after release.
- key_valid=1 with a different key during EMIT: ignored, key_ready=0 throughout, round keys match the first key.
- Reset (rst=0) asynchronously at rk_round=5 mid-cycle:
  - rk_valid=0 and rk=0 before the next clock edge;
  - after release key_ready=1;
  - a new key yields round0 on the following cycle.
- Random rk_ready toggling over 100 random keys: the 11 keys per run are checked against a reference model, with no key skipped or duplicated.

Source files
------------

// File: rtl/key_sched_stream_pkg.sv
// rtl/key_sched_stream_pkg.sv - shared AES types, round constants, FSM states and GF(2^8) helpers
package key_sched_stream_pkg;

  localparam int NR = 10;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_t;
  typedef word_t [0:3] block_t;

  localparam byte_t RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {IDLE, EMIT} ks_state_e;

  function automatic byte_t xtime(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p;
    byte_t t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/key_sched_next.sv
// rtl/key_sched_next.sv - combinational AES-128 next-round-key function
module key_sched_next
  import key_sched_stream_pkg::*;
(
  input  logic [0:3][0:3][7:0] rk,
  input  logic [7:0]           rc,
  output logic [0:3][0:3][7:0] nk
);

  word_t sub;
  word_t t;
  word_t w0;
  word_t w1;
  word_t w2;
  word_t w3;

  // RotWord folded into the S-box input selection
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    localparam int J = (i + 1) % 4;
    sbox u_sbox (
      .x (rk[3][J]),
      .y (sub[i])
    );
  end

  always_comb begin
    t     = sub;
    t[0]  = sub[0] ^ rc;
    w0    = rk[0] ^ t;
    w1    = rk[1] ^ w0;
    w2    = rk[2] ^ w1;
    w3    = rk[3] ^ w2;
    nk[0] = w0;
    nk[1] = w1;
    nk[2] = w2;
    nk[3] = w3;
  end

endmodule

// File: rtl/sbox.sv
// rtl/sbox.sv - AES forward S-box: GF(2^8) multiplicative inverse followed by the affine map
module sbox
  import key_sched_stream_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  byte_t sq;
  byte_t inv;

  // x^254 == x^-1 (and 0 -> 0), built as x^2 * x^4 * ... * x^128
  always_comb begin
    sq  = gf_mul(x, x);
    inv = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/key_sched_stream.sv
// rtl/key_sched_stream.sv - iterative AES-128 key schedule streaming round keys 0..NR
module key_sched_stream
  import key_sched_stream_pkg::*;
#(
  parameter int NR = key_sched_stream_pkg::NR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:3][0:3][7:0] key,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic [0:3][0:3][7:0] rk,
  output logic [3:0]           rk_round,
  output logic                 rk_last,
  output logic                 rk_valid,
  input  logic                 rk_ready
);

  if (NR != 10) begin : g_nr_check
    $error("key_sched_stream supports only NR = 10 (AES-128)");
  end

  localparam logic [3:0] LAST = 4'(NR);

  ks_state_e            state;
  ks_state_e            state_next;
  logic                 load;
  logic                 advance;
  logic [7:0]           rc;
  logic [0:3][0:3][7:0] rk_next;

  assign rc = (rk_round < LAST) ? RCON[rk_round] : 8'h00;

  key_sched_next u_next (
    .rk (rk),
    .rc (rc),
    .nk (rk_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    rk_valid   = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load       = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (rk_round == LAST) state_next = IDLE;
          else                  advance    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // rk/rk_round/rk_last hold on backpressure and after the final handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk       <= '0;
      rk_round <= 4'd0;
      rk_last  <= 1'b0;
    end else if (load) begin
      rk       <= key;
      rk_round <= 4'd0;
      rk_last  <= 1'b0;
    end else if (advance) begin
      rk       <= rk_next;
      rk_round <= rk_round + 4'd1;
      rk_last  <= (rk_round + 4'd1 == LAST);
    end
  end

endmodule

// File: tb/tb_key_sched_stream.sv
// tb/tb_key_sched_stream.sv - randomized self-checking bench for key_sched_stream
module tb_key_sched_stream;

  logic                 clk;
  logic                 rst;
  logic [0:3][0:3][7:0] key;
  logic                 key_valid;
  logic                 key_ready;
  logic [0:3][0:3][7:0] rk;
  logic [3:0]           rk_round;
  logic                 rk_last;
  logic                 rk_valid;
  logic                 rk_ready;

  key_sched_stream dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk        (rk),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready)
  );

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sb     [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];
  int           n_got;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from log/antilog tables over generator 3, then the affine map bit by bit
  task automatic build_sbox();
    int exp_t [0:255];
    int log_t [0:255];
    logic [7:0] e;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    e = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 256; i++) log_t[i] = 0;
    for (int i = 0; i < 255; i++) begin
      exp_t[i]      = int'(e);
      log_t[int'(e)] = i;
      e = e ^ mul2(e);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : 8'(exp_t[(255 - log_t[x]) % 255]);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8]
                      ^ inv[(b + 7) % 8] ^ c[b];
      sb[x] = s;
    end
  endtask

  // Textbook 44-word expansion
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = mul2(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles at round 2, 3: foreign key_valid during EMIT
  task automatic run_stream(input logic [127:0] k, input int mode, output int ready_cyc);
    int           cyc;
    int           stall;
    bit           prev_stall;
    logic [127:0] prev_rk;
    logic [3:0]   prev_round;
    model_expand(k);
    @(negedge clk);
    key       = k;
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    check("accept_ready", key_ready, 1);
    @(posedge clk);
    cyc        = 1;
    n_got      = 0;
    stall      = 0;
    prev_stall = 0;
    prev_rk    = '0;
    prev_round = '0;
    ready_cyc  = -1;
    @(negedge clk);
    check("first_valid", rk_valid, 1);
    while (cyc < 200) begin
      if (key_ready) begin
        key_valid = 1'b0;
        ready_cyc = cyc;
        break;
      end
      if (mode == 3) begin
        key_valid = 1'b1;
        key       = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        key_valid = 1'b0;
      end
      check("ready_low", key_ready, 0);
      check("valid_high", rk_valid, 1);
      if (prev_stall) begin
        check("hold_rk", rk, prev_rk);
        check("hold_round", rk_round, prev_round);
      end
      if (mode == 1) rk_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && rk_round == 4'd2 && stall < 3) begin
        rk_ready = 1'b0;
        stall++;
        check("bp_rk", rk, A1_R2);
      end else rk_ready = 1'b1;
      if (rk_ready) begin
        if (n_got <= 10) begin
          check("rk", rk, exp_rk[n_got]);
          check("round", rk_round, n_got);
          check("last", rk_last, (n_got == 10));
          got_rk[n_got] = rk;
        end
        n_got++;
      end
      prev_stall = !rk_ready;
      prev_rk    = rk;
      prev_round = rk_round;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("stream_done", (ready_cyc > 0), 1);
    check("key_count", n_got, 11);
  endtask

  initial begin
    int rc_cyc;
    int n;
    rst       = 1'b0;
    key       = '0;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("rst_ready", key_ready, 1);
    check("rst_valid", rk_valid, 0);
    check("rst_rk", rk, 0);
    check("rst_round", rk_round, 0);
    check("rst_last", rk_last, 0);
    rst = 1'b1;

    run_stream(A1_KEY, 0, rc_cyc);
    check("a1_ready_latency", rc_cyc, 12);
    check("a1_r0", got_rk[0], A1_KEY);
    check("a1_r1", got_rk[1], A1_R1);
    check("a1_r10", got_rk[10], A1_R10);

    rk_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_valid", rk_valid, 0);
      check("idle_round", rk_round, 10);
      check("idle_rk", rk, A1_R10);
      check("idle_last", rk_last, 1);
    end

    run_stream(128'h0, 0, rc_cyc);
    check("zero_r1", got_rk[1], Z_R1);
    check("zero_r10", got_rk[10], Z_R10);

    run_stream(A1_KEY, 2, rc_cyc);
    check("bp_r3", got_rk[3], exp_rk[3]);

    run_stream(A1_KEY, 3, rc_cyc);
    check("noisy_r10", got_rk[10], A1_R10);

    @(negedge clk);
    key       = A1_KEY;
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    n = 0;
    while (rk_round != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_round", rk_round, 5);
    #1 rst = 1'b0;
    #1;
    check("arst_valid", rk_valid, 0);
    check("arst_rk", rk, 0);
    check("arst_ready", key_ready, 1);
    check("arst_round", rk_round, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_valid", rk_valid, 0);
      check("post_rst_ready", key_ready, 1);
    end
    run_stream({$urandom, $urandom, $urandom, $urandom}, 0, rc_cyc);

    for (int i = 0; i < 100; i++)
      run_stream({$urandom, $urandom, $urandom, $urandom}, 1, rc_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
